led_phase_scheduler: RTL

LED_PHASE_SCHEDULER -- requirements
Module: led_phase_scheduler

---
 rtl/led_phase_scheduler.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/led_phase_scheduler.sv
// LED phase scheduler: cycles RED/IR LED phases and captures one ADC sample per phase.
// Define LED_PHASE_DARK_EN to append an ambient DARK phase (both LEDs off) to every frame.
module led_phase_scheduler #(
  parameter int unsigned PHASE_LEN  = 10,
  parameter int unsigned SAMPLE_IDX = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       enable,
  input  logic       cfg_valid,
  input  logic [6:0] cfg_red_dc,
  input  logic [6:0] cfg_ir_dc,
  input  logic [3:0] cfg_red_pga,
  input  logic [3:0] cfg_ir_pga,
  input  logic [3:0] cfg_led_drive,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [3:0] LED_DRIVE,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic [7:0] DARK_ADC_Value,
  output logic       red_valid,
  output logic       ir_valid,
  output logic       dark_valid,
  output logic       frame_done,
  output logic       busy
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RED  = 2'd1;
  localparam logic [1:0] ST_IR   = 2'd2;
  localparam logic [1:0] ST_DARK = 2'd3;

  localparam logic [7:0] LP_LAST      = 8'(PHASE_LEN - 1);
  localparam logic [7:0] LP_SAMPLE    = 8'(SAMPLE_IDX);
  localparam logic [6:0] LP_DC_RST    = 7'd64;
  localparam logic [3:0] LP_DRIVE_RST = 4'd10;

  logic [1:0] r_state, w_state_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic [6:0] r_sh_red_dc, r_sh_ir_dc, r_act_red_dc, r_act_ir_dc;
  logic [3:0] r_sh_red_pga, r_sh_ir_pga, r_sh_drive;
  logic [3:0] r_act_red_pga, r_act_ir_pga, r_act_drive;
  logic [6:0] w_sh_red_dc, w_sh_ir_dc, w_act_red_dc, w_act_ir_dc;
  logic [3:0] w_sh_red_pga, w_sh_ir_pga, w_sh_drive;
  logic [3:0] w_act_red_pga, w_act_ir_pga, w_act_drive;
  logic       w_last, w_capture, w_red_entry, w_frame_end;
  logic [6:0] w_dc_d;
  logic [3:0] w_pga_d, w_drive_d;
  logic       r_led_red, r_led_ir, r_red_valid, r_ir_valid, r_frame_done, r_busy;
  logic [6:0] r_dc;
  logic [3:0] r_pga, r_drive;
  logic [7:0] r_red_adc, r_ir_adc;

  assign w_last    = (r_cnt == LP_LAST);
  assign w_capture = enable && (r_state != ST_IDLE) && (r_cnt == LP_SAMPLE);

  always_comb begin
    w_state_d   = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: if (enable) w_state_d = ST_RED;
      ST_RED: begin
        if (!enable)     w_state_d = ST_IDLE;
        else if (w_last) w_state_d = ST_IR;
      end
      ST_IR: begin
        if (!enable) begin
          w_state_d = ST_IDLE;
        end else if (w_last) begin
`ifdef LED_PHASE_DARK_EN
          w_state_d   = ST_DARK;
`else
          w_state_d   = ST_RED;
          w_frame_end = 1'b1;
`endif
        end
      end
`ifdef LED_PHASE_DARK_EN
      ST_DARK: begin
        if (!enable) begin
          w_state_d = ST_IDLE;
        end else if (w_last) begin
          w_state_d   = ST_RED;
          w_frame_end = 1'b1;
        end
      end
`endif
      default: w_state_d = ST_IDLE;
    endcase
  end

  assign w_cnt_d     = (w_state_d != r_state || w_state_d == ST_IDLE) ? 8'd0 : r_cnt + 8'd1;
  assign w_red_entry = (w_state_d == ST_RED) && (r_state != ST_RED);

  // A cfg write landing on the RED-entry edge is forwarded straight into the active set.
  assign w_sh_red_dc   = cfg_valid ? cfg_red_dc    : r_sh_red_dc;
  assign w_sh_ir_dc    = cfg_valid ? cfg_ir_dc     : r_sh_ir_dc;
  assign w_sh_red_pga  = cfg_valid ? cfg_red_pga   : r_sh_red_pga;
  assign w_sh_ir_pga   = cfg_valid ? cfg_ir_pga    : r_sh_ir_pga;
  assign w_sh_drive    = cfg_valid ? cfg_led_drive : r_sh_drive;
  assign w_act_red_dc  = w_red_entry ? w_sh_red_dc  : r_act_red_dc;
  assign w_act_ir_dc   = w_red_entry ? w_sh_ir_dc   : r_act_ir_dc;
  assign w_act_red_pga = w_red_entry ? w_sh_red_pga : r_act_red_pga;
  assign w_act_ir_pga  = w_red_entry ? w_sh_ir_pga  : r_act_ir_pga;
  assign w_act_drive   = w_red_entry ? w_sh_drive   : r_act_drive;

  always_comb begin
    w_dc_d    = LP_DC_RST;
    w_pga_d   = 4'd0;
    w_drive_d = 4'd0;
    case (w_state_d)
      ST_RED:  begin w_dc_d = w_act_red_dc; w_pga_d = w_act_red_pga; w_drive_d = w_act_drive; end
      ST_IR:   begin w_dc_d = w_act_ir_dc;  w_pga_d = w_act_ir_pga;  w_drive_d = w_act_drive; end
      ST_DARK: begin w_dc_d = w_act_ir_dc;  w_pga_d = w_act_ir_pga; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_sh_red_dc   <= LP_DC_RST;
      r_sh_ir_dc    <= LP_DC_RST;
      r_sh_red_pga  <= 4'd0;
      r_sh_ir_pga   <= 4'd0;
      r_sh_drive    <= LP_DRIVE_RST;
      r_act_red_dc  <= LP_DC_RST;
      r_act_ir_dc   <= LP_DC_RST;
      r_act_red_pga <= 4'd0;
      r_act_ir_pga  <= 4'd0;
      r_act_drive   <= LP_DRIVE_RST;
      r_led_red     <= 1'b0;
      r_led_ir      <= 1'b0;
      r_dc          <= LP_DC_RST;
      r_pga         <= 4'd0;
      r_drive       <= 4'd0;
      r_red_adc     <= 8'd0;
      r_ir_adc      <= 8'd0;
      r_red_valid   <= 1'b0;
      r_ir_valid    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_sh_red_dc   <= w_sh_red_dc;
      r_sh_ir_dc    <= w_sh_ir_dc;
      r_sh_red_pga  <= w_sh_red_pga;
      r_sh_ir_pga   <= w_sh_ir_pga;
      r_sh_drive    <= w_sh_drive;
      r_act_red_dc  <= w_act_red_dc;
      r_act_ir_dc   <= w_act_ir_dc;
      r_act_red_pga <= w_act_red_pga;
      r_act_ir_pga  <= w_act_ir_pga;
      r_act_drive   <= w_act_drive;
      r_led_red     <= (w_state_d == ST_RED);
      r_led_ir      <= (w_state_d == ST_IR);
      r_dc          <= w_dc_d;
      r_pga         <= w_pga_d;
      r_drive       <= w_drive_d;
      r_red_valid   <= w_capture && (r_state == ST_RED);
      r_ir_valid    <= w_capture && (r_state == ST_IR);
      r_frame_done  <= w_frame_end;
      r_busy        <= (w_state_d != ST_IDLE);
      if (w_capture && r_state == ST_RED) r_red_adc <= ADC;
      if (w_capture && r_state == ST_IR)  r_ir_adc  <= ADC;
    end
  end

`ifdef LED_PHASE_DARK_EN
  logic [7:0] r_dark_adc;
  logic       r_dark_valid;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_dark_adc   <= 8'd0;
      r_dark_valid <= 1'b0;
    end else begin
      r_dark_valid <= w_capture && (r_state == ST_DARK);
      if (w_capture && r_state == ST_DARK) r_dark_adc <= ADC;
    end
  end

  assign DARK_ADC_Value = r_dark_adc;
  assign dark_valid     = r_dark_valid;
`else
  assign DARK_ADC_Value = 8'd0;
  assign dark_valid     = 1'b0;
`endif

  assign LED_RED       = r_led_red;
  assign LED_IR        = r_led_ir;
  assign DC_Comp       = r_dc;
  assign PGA_Gain      = r_pga;
  assign LED_DRIVE     = r_drive;
  assign RED_ADC_Value = r_red_adc;
  assign IR_ADC_Value  = r_ir_adc;
  assign red_valid     = r_red_valid;
  assign ir_valid      = r_ir_valid;
  assign frame_done    = r_frame_done;
  assign busy          = r_busy;

endmodule
